// File: rtl/bus_arb_pkg.sv
// Shared definitions for the fixed-priority bus arbiter: FSM state encoding,
// the widest supported requester count and the default ownership limit.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int N_REQ_MAX          = 8;
    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/arb_pri_sel.sv
// Combinational masked fixed-priority selector: picks the lowest-index request
// whose mask bit is clear and reports it as one-hot, binary index and a valid flag.
module arb_pri_sel #(
    parameter int N_REQ = 8
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         mask,
    output logic [N_REQ-1:0]         onehot,
    output logic [$clog2(N_REQ)-1:0] index,
    output logic                     any
);

    localparam int IDW = $clog2(N_REQ);

    // Scan from the highest index down so the lowest eligible index is written last and wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && !mask[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IDW'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Fixed-priority bus arbiter with a registered one-hot grant that is held until
// the owner releases its request. Every hand-over passes through one idle
// turnaround cycle. Defining ARB_TIMEOUT_EN adds an ownership cycle limit that
// forces a revoke, pulses timeout and locks the offender out until it drops req.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ          = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     bus_busy,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_t         state;
    logic [N_REQ-1:0]   sel_mask;
    logic [N_REQ-1:0]   sel_onehot;
    logic [IDW-1:0]     sel_index;
    logic               sel_any;
    logic               owner_req;

    // The current owner is still requesting when its own req bit is high.
    assign owner_req = |(req & grant);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   own_cnt;
    logic [N_REQ-1:0]   lockout_mask;

    assign sel_mask = lockout_mask;
`else
    assign sel_mask = '0;
`endif

    arb_pri_sel #(
        .N_REQ (N_REQ)
    ) u_sel (
        .req    (req),
        .mask   (sel_mask),
        .onehot (sel_onehot),
        .index  (sel_index),
        .any    (sel_any)
    );

    // Arbitration FSM with registered grant, owner index, busy flag and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            own_cnt      <= '0;
            lockout_mask <= '0;
`endif
        end else begin
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            lockout_mask <= lockout_mask & req;
`endif
            case (state)
                IDLE, TURN: begin
                    if (sel_any) begin
                        state    <= OWN;
                        grant    <= sel_onehot;
                        owner_id <= sel_index;
                        bus_busy <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        own_cnt  <= '0;
`endif
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        owner_id <= '0;
                        bus_busy <= 1'b0;
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        state    <= TURN;
                        grant    <= '0;
                        owner_id <= '0;
                        bus_busy <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (own_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state        <= TURN;
                        grant        <= '0;
                        owner_id     <= '0;
                        bus_busy     <= 1'b0;
                        timeout      <= 1'b1;
                        lockout_mask <= (lockout_mask & req) | grant;
                    end else begin
                        own_cnt <= own_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    owner_id <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a behavioural ownership model checked on
// every falling edge, plus directed vectors with hand-computed expectations.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

    localparam int N  = 8;
    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [2:0]   owner_id;
    logic         bus_busy;
    logic         timeout;

    int tests_run    = 0;
    int tests_failed = 0;
    bit checks_on    = 1'b0;

    // Model state: who owns the bus (-1 = nobody), how long, and lockouts.
    int       m_owner = -1;
    int       m_held  = 0;
    bit       m_to    = 1'b0;
    bit [N-1:0] m_mask = '0;

    bus_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_grant();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic logic [2:0] m_id();
        return (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    endfunction

    // Ownership model: a free bus goes to the lowest unmasked requester; an owner
    // keeps it until it drops req or (optionally) exhausts its cycle allowance.
    always @(posedge clk) begin
        bit [N-1:0] set_bits;
        set_bits = '0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_to    = 1'b0;
            m_mask  = '0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                end else if (TO_EN && m_held == TO) begin
                    set_bits[m_owner] = 1'b1;
                    m_owner = -1;
                    m_to    = 1'b1;
                end else begin
                    m_held++;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_owner < 0 && req[i] && !(TO_EN && m_mask[i])) begin
                        m_owner = i;
                        m_held  = 1;
                    end
                end
            end
            m_mask = (m_mask & req) | set_bits;
        end
    end

    // Continuous comparison of the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checks_on) begin
            tests_run++;
            if (grant !== m_grant() || owner_id !== m_id() ||
                bus_busy !== (m_owner >= 0) || timeout !== m_to) begin
                tests_failed++;
                $display("[TB] FAIL model_cmp t=%0t: grant=%h id=%0d busy=%b to=%b, required grant=%h id=%0d busy=%b to=%b",
                         $time, grant, owner_id, bus_busy, timeout,
                         m_grant(), m_id(), (m_owner >= 0), m_to);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [N-1:0] q, input int cycles);
        rst = r;
        req = q;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg,
                               input logic [2:0] eid, input logic eb, input logic et);
        tests_run++;
        if (grant !== eg || owner_id !== eid || bus_busy !== eb || timeout !== et) begin
            tests_failed++;
            $display("[TB] FAIL %s: grant=%h id=%0d busy=%b to=%b, required grant=%h id=%0d busy=%b to=%b",
                     name, grant, owner_id, bus_busy, timeout, eg, eid, eb, et);
        end
        tests_run++;
        if (m_grant() !== eg || m_id() !== eid || m_to !== et) begin
            tests_failed++;
            $display("[TB] FAIL %s_model: grant=%h id=%0d to=%b, required grant=%h id=%0d to=%b",
                     name, m_grant(), m_id(), m_to, eg, eid, et);
        end
    endtask

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] g;
        logic [2:0]   id;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'h80, 8'h80, 3'd7},
        '{8'hFF, 8'h01, 3'd0},
        '{8'hC0, 8'h40, 3'd6},
        '{8'h06, 8'h02, 3'd1}
    };

    initial begin
        #2;
        applyStimulus(1'b1, 8'h00, 2);
        checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        checks_on = 1'b1;

        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("idle", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h10, 1);
        checkOutput("single_req", 8'h10, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("release_turn", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("release_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        applyStimulus(1'b0, 8'hA4, 1);
        checkOutput("simultaneous", 8'h04, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hA5, 1);
        checkOutput("no_preempt", 8'h04, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hA5, 2);
        checkOutput("hold", 8'h04, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hA0, 1);
        checkOutput("handover_turn", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hA0, 1);
        checkOutput("handover_grant", 8'h20, 3'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("to_idle_turn", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("to_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        applyStimulus(1'b0, 8'h08, 1);
        checkOutput("pre_reset_own", 8'h08, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h08, 1);
        checkOutput("reset_mid_own", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h08, 1);
        checkOutput("regrant_after_reset", 8'h08, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 2);
        checkOutput("after_reset_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, vecs[k].q, 1);
            checkOutput($sformatf("priority_%0d", k), vecs[k].g, vecs[k].id, 1'b1, 1'b0);
            applyStimulus(1'b0, 8'h00, 2);
        end

`ifdef ARB_TIMEOUT_EN
        applyStimulus(1'b0, 8'h03, 1);
        checkOutput("to_own_first", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h03, 3);
        checkOutput("to_own_last", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h03, 1);
        checkOutput("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h03, 1);
        checkOutput("to_next_owner", 8'h02, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 1);
        checkOutput("to_release_turn", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h01, 1);
        checkOutput("to_locked_out", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("to_unlock", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h01, 1);
        checkOutput("to_regrant", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 2);
`endif

        checks_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
